// File: rtl/vga_timing_pkg.sv
// VGA timing shared definitions: default 640x480@60 porch/sync lengths,
// derived line/frame totals, coordinate width and the blanking-phase enum.
// No ports; imported by vga_phase_counter and vga_timing_ctrl.
package vga_timing_pkg;

  localparam int COORD_W      = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

endpackage

// File: rtl/vga_phase_counter.sv
// Wrapping position counter (0..ACTIVE+FP+SYNC+BP-1) with a phase FSM that
// tracks which region the current count lies in; used once per axis.
// Ports: clk, rst_n, adv_i (step by one), cnt_o (position), phase_o
// (phase_t of cnt_o), last_o (cnt_o is the final position, next step wraps).
module vga_phase_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CNT_W  = COORD_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic [1:0]       phase_o,
  output logic             last_o
);

  // Last count value of each region; the phase moves on when the count
  // leaves that value.
  localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(ACTIVE - 1);
  localparam logic [CNT_W-1:0] END_FP   = CNT_W'(ACTIVE + FP - 1);
  localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(ACTIVE + FP + SYNC + BP - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  phase_t           phase_q, phase_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= PH_ACTIVE;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (adv_i) begin
      if (cnt_q == LAST) cnt_d = '0;
      else               cnt_d = cnt_q + CNT_W'(1);
      case (phase_q)
        PH_ACTIVE: if (cnt_q == END_ACT)  phase_d = PH_FRONT;
        PH_FRONT:  if (cnt_q == END_FP)   phase_d = PH_SYNC;
        PH_SYNC:   if (cnt_q == END_SYNC) phase_d = PH_BACK;
        PH_BACK:   if (cnt_q == LAST)     phase_d = PH_ACTIVE;
        default:                          phase_d = PH_ACTIVE;
      endcase
    end
  end

  assign cnt_o   = cnt_q;
  assign phase_o = phase_q;
  assign last_o  = (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing generator: h/v phase counters decoded into registered
// syncs, display enable, coordinates, line/frame strobes and a frame counter.
// Ports: clk, rst_n (async, active-low), ena (advance/freeze); outputs hsync,
// vsync (active-low), de, x, y, line_start, frame_start, frame_cnt -- all
// registered one clock behind the counters and held while ena is low.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_start,
  output logic               frame_start,
  output logic [7:0]         frame_cnt
);

  logic [COORD_W-1:0] h_cnt, v_cnt;
  logic [1:0]         h_phase, v_phase;
  logic               h_last, v_last;
  logic               v_adv;

  // The line counter steps on the same clock the pixel counter wraps.
  assign v_adv = ena & h_last;

  vga_phase_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_W(COORD_W)
  ) u_h (
    .clk(clk), .rst_n(rst_n), .adv_i(ena),
    .cnt_o(h_cnt), .phase_o(h_phase), .last_o(h_last)
  );

  vga_phase_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_W(COORD_W)
  ) u_v (
    .clk(clk), .rst_n(rst_n), .adv_i(v_adv),
    .cnt_o(v_cnt), .phase_o(v_phase), .last_o(v_last)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               de_q, de_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  // fcnt_q counts wraps as the counters cross into a new frame; frame_cnt_q
  // copies it one clock later so the visible value changes together with
  // the frame_start output of the new frame.
  logic [7:0]         fcnt_q, fcnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    fcnt_d        = fcnt_q;
    frame_cnt_d   = frame_cnt_q;
    if (ena) begin
      hsync_d       = (h_phase != PH_SYNC);
      vsync_d       = (v_phase != PH_SYNC);
      de_d          = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
      x_d           = h_cnt;
      y_d           = v_cnt;
      line_start_d  = (h_cnt == '0);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      frame_cnt_d   = fcnt_q;
      if (h_last && v_last) fcnt_d = fcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      fcnt_q        <= '0;
      frame_cnt_q   <= '0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      fcnt_q        <= fcnt_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in clocks.
REQ-003 Parameter H_SYNC, default 96, hsync pulse width in clocks.
REQ-004 Parameter H_BP, default 48, horizontal back porch in clocks.
REQ-005 Parameters V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33, same meanings in lines.
REQ-006 clk  input  1  pixel clock (25 MHz nominal); the design SHALL use this single clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 ena  input  1  run enable; high = timing advances, low = freeze.
REQ-009 hsync  output  1  horizontal sync, active-low.
REQ-010 vsync  output  1  vertical sync, active-low.
REQ-011 de  output  1  display enable, high in the visible region only.
REQ-012 x  output  10  current pixel column.
REQ-013 y  output  10  current line.
REQ-014 line_start  output  1  one-cycle pulse at x=0.
REQ-015 frame_start  output  1  one-cycle pulse at x=0, y=0.
REQ-016 frame_cnt  output  8  completed-frame counter for animation (sky scroll).

Function
REQ-017 The internal h counter SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params = 800) and wrap to 0.
REQ-018 The v counter SHALL advance only on h wrap, counting 0..V_TOTAL-1 (525) and wrapping to 0.
REQ-019 The h phase FSM SHALL have states ACTIVE (h<640), FRONT (640..655), SYNC (656..751) and BACK (752..799), transitioning only at those boundaries; the v phase FSM SHALL be identical in lines (480, 490, 492, 525).
REQ-020 hsync SHALL be 0 exactly while h is in SYNC, and vsync SHALL be 0 exactly while v is in SYNC, both independent of the other axis.
REQ-021 de SHALL equal (h in ACTIVE) AND (v in ACTIVE).
REQ-022 x/y SHALL equal h/v in every cycle, including blanking.
REQ-023 All outputs SHALL be registered, lagging the counter state by exactly 1 clock, and mutually aligned in the same cycle.
REQ-024 line_start SHALL assert for the single output cycle where x=0; frame_start SHALL assert where x=0 and y=0.
REQ-025 frame_cnt SHALL increment by 1 on each v wrap (524 to 0) and wrap 255 to 0 without saturating; the first frame after reset SHALL NOT increment it.
REQ-026 While ena=0, the counters, FSMs and all outputs SHALL hold, and strobes SHALL be held too; the next ena=1 clock SHALL resume from the held position.
REQ-027 Simultaneous h wrap and v wrap SHALL advance both counters in one clock, producing frame_start together with a frame_cnt increment.

Reset
REQ-028 Asserting rst_n=0 SHALL immediately force h=0, v=0, hsync=1, vsync=1, de=0, x=0, y=0, line_start=0, frame_start=0 and frame_cnt=0.
REQ-029 At the first ena=1 edge after release, the outputs SHALL show x=0, y=0, de=1, line_start=1 and frame_start=1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame with no partial sync pulse retained.

Structure
REQ-031 Timing defaults, derived H_TOTAL/V_TOTAL, and the phase enum (ACTIVE, FRONT, SYNC, BACK) SHALL live in a shared package, vga_timing_pkg.
REQ-032 The design SHALL use one sub-module, vga_phase_counter (wrapping counter plus phase decode, parameterised by the four lengths), instantiated once for h and once for v.

Verification
REQ-033 Scenario: reset, then ena=1, 1 clock -> x=0, y=0, de=1, line_start=1, frame_start=1, hsync=1, vsync=1, frame_cnt=0.
REQ-034 Scenario: run 1 line -> hsync low for exactly 96 clocks starting at x=656; line_start period is 800 clocks; de high for 640 clocks.
REQ-035 Scenario: run 1 frame -> frame_start period is 420000 clocks; vsync low on y=490..491 for 1600 clocks; de high for 307200 clocks; frame_cnt=1 at the next frame_start.
REQ-036 Scenario: ena=0 for 50 clocks at x=700, y=100 -> all outputs constant; resume continues at x=701.
REQ-037 Scenario: rst_n pulsed low at x=700, y=491 (in sync) -> hsync=1, vsync=1 and counters 0 asynchronously, before the next clk edge.
REQ-038 Scenario: run 256 frames -> frame_cnt wraps 255 to 0 coincident with frame_start.
